// File: rtl/cmp42_bank_arbiter_if.sv
// Request/response bus between the partial-product generators and the shared
// pro_4 compressor bank.
`timescale 1ns/1ps
interface cmp42_bank_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int LANES = 8
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*LANES-1:0] req_a;
  logic [NREQ*LANES-1:0] req_b;
  logic [NREQ*LANES-1:0] req_c;
  logic [NREQ*LANES-1:0] req_d;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [LANES-1:0]      rsp_s;
  logic [LANES-1:0]      rsp_c;
  logic [1:0]            rsp_id;
  logic [15:0]           ops_cnt;

  modport master (
    output req_valid, req_a, req_b, req_c, req_d, rsp_ready,
    input  req_ready, rsp_valid, rsp_s, rsp_c, rsp_id, ops_cnt
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c, req_d, rsp_ready,
    output req_ready, rsp_valid, rsp_s, rsp_c, rsp_id, ops_cnt
  );
endinterface

// File: rtl/cmp42_bank_arbiter.sv
// Round-robin sharing of one bank of approximate 4-2 compressors (pro_4)
// among NREQ requesters, with a two-stage pipeline and tagged responses.
`timescale 1ns/1ps
module pro_4 (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic s,
  output logic co
);
  logic t1;
  logic t2;

  assign t1 = a ^ b;
  assign t2 = c ^ d;
  assign s  = t1 ? t2 : ~(c | d);
  assign co = ~((~(a | b) & ~(c & d)) | (~(c | d) & ~(a & b)));
endmodule

module cmp42_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int LANES = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  cmp42_bank_arbiter_if.slave bus
);
  logic [1:0]       rr_ptr;
  logic [NREQ-1:0]  grant;
  logic [1:0]       grant_id;
  logic [1:0]       cand;
  logic             found;
  logic             xfer;
  logic             load_ok_p1;
  logic             adv_p1;
  logic             rsp_fire;

  logic             vld_p1;
  logic [1:0]       id_p1;
  logic [LANES-1:0] a_p1;
  logic [LANES-1:0] b_p1;
  logic [LANES-1:0] c_p1;
  logic [LANES-1:0] d_p1;

  logic [LANES-1:0] s_bank;
  logic [LANES-1:0] c_bank;

  logic             vld_p2;
  logic [1:0]       id_p2;
  logic [LANES-1:0] s_p2;
  logic [LANES-1:0] c_p2;
  logic [15:0]      ops_cnt_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [1:0] ptr_after(input logic [1:0] id);
    return 2'((int'(id) + 1) % NREQ);
  endfunction

  // Grant depends only on req_valid and rr_ptr, so it never loops back on ready.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    cand     = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = 2'((int'(rr_ptr) + k) % NREQ);
      if (!found && bus.req_valid[cand]) begin
        grant[cand] = 1'b1;
        grant_id    = cand;
        found       = 1'b1;
      end
    end
  end

  assign adv_p1        = vld_p1 & (~vld_p2 | bus.rsp_ready);
  assign load_ok_p1    = ~vld_p1 | adv_p1;
  assign bus.req_ready = grant & {NREQ{load_ok_p1}};
  assign xfer          = |(bus.req_valid & bus.req_ready);
  assign rsp_fire      = vld_p2 & bus.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= ptr_after(grant_id);
    end
  end

  // Stage 0 -> 1: register the granted operands and their requester id.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (load_ok_p1) begin
      vld_p1 <= xfer;
    end
  end

  always_ff @(posedge clk) begin
    if (load_ok_p1 && xfer) begin
      id_p1 <= grant_id;
      a_p1  <= bus.req_a[int'(grant_id)*LANES +: LANES];
      b_p1  <= bus.req_b[int'(grant_id)*LANES +: LANES];
      c_p1  <= bus.req_c[int'(grant_id)*LANES +: LANES];
      d_p1  <= bus.req_d[int'(grant_id)*LANES +: LANES];
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    pro_4 u_cell (
      .a  (a_p1[j]),
      .b  (b_p1[j]),
      .c  (c_p1[j]),
      .d  (d_p1[j]),
      .s  (s_bank[j]),
      .co (c_bank[j])
    );
  end

  // Stage 1 -> 2: capture compressor outputs; the response port holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      id_p2  <= '0;
      s_p2   <= '0;
      c_p2   <= '0;
    end else if (adv_p1) begin
      vld_p2 <= 1'b1;
      id_p2  <= id_p1;
      s_p2   <= s_bank;
      c_p2   <= c_bank;
    end else if (rsp_fire) begin
      vld_p2 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_cnt_q <= '0;
    end else if (rsp_fire) begin
      ops_cnt_q <= sat_inc16(ops_cnt_q);
    end
  end

  assign bus.rsp_valid = vld_p2;
  assign bus.rsp_s     = s_p2;
  assign bus.rsp_c     = c_p2;
  assign bus.rsp_id    = id_p2;
  assign bus.ops_cnt   = ops_cnt_q;
endmodule

// File: tb/tb_cmp42_bank_arbiter.sv
// Directed bench for cmp42_bank_arbiter: vector table plus arbitration,
// backpressure, reset and counter-saturation sequences.
`timescale 1ns/1ps
module tb_cmp42_bank_arbiter;
  localparam int NREQ  = 4;
  localparam int LANES = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cmp42_bank_arbiter_if #(.NREQ(NREQ), .LANES(LANES)) bus ();
  cmp42_bank_arbiter #(.NREQ(NREQ), .LANES(LANES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] d;
    logic [7:0] s;
    logic [7:0] co;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_ops(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
    bus.req_a[id*LANES +: LANES] = a;
    bus.req_b[id*LANES +: LANES] = b;
    bus.req_c[id*LANES +: LANES] = c;
    bus.req_d[id*LANES +: LANES] = d;
  endtask

  // Called just after a falling edge; returns just after the falling edge
  // that follows the accepting rising edge.
  task automatic do_xfer(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
    logic got;
    got = 1'b0;
    set_ops(id, a, b, c, d);
    bus.req_valid[id] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      got = bus.req_ready[id];
      @(negedge clk);
      if (got) break;
    end
    bus.req_valid[id] = 1'b0;
    if (!got) chk("xfer_timeout", 32'd0, 32'd1);
  endtask

  // Requesters must hold valid until accepted.
  logic [NREQ-1:0] pend = '0;
  always @(posedge clk) begin
    if (!rst_n) begin
      pend = '0;
    end else begin
      if (pend != '0) begin
        total++;
        if ((pend & ~bus.req_valid) != '0) begin
          bad++;
          $display("FAIL req_hold: valid=%b pending=%b", bus.req_valid, pend);
        end
      end
      pend = bus.req_valid & ~bus.req_ready;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t       vt[7];
  logic [7:0] rr_s[4];
  logic [7:0] rr_c[4];
  logic [3:0] g;
  int         k;

  initial begin
    vt[0] = '{0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF};
    vt[1] = '{2, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00};
    vt[2] = '{2, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF};
    vt[3] = '{1, 8'hAA, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[4] = '{3, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00};
    vt[5] = '{0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00};
    vt[6] = '{3, 8'h0F, 8'h0F, 8'hF0, 8'h00, 8'h0F, 8'h0F};
    rr_s = '{8'h00, 8'hFF, 8'h0F, 8'hFF};
    rr_c = '{8'hFF, 8'h00, 8'h00, 8'hFF};

    bus.req_valid = '0;
    bus.req_a = '0; bus.req_b = '0; bus.req_c = '0; bus.req_d = '0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready, 4'b0000);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_s", bus.rsp_s, 8'h00);
    chk("rst_rsp_c", bus.rsp_c, 8'h00);
    chk("rst_rsp_id", bus.rsp_id, 2'd0);
    chk("rst_ops_cnt", bus.ops_cnt, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);

    // Single requests from the vector table, two-cycle latency.
    for (int i = 0; i < 7; i++) begin
      do_xfer(vt[i].id, vt[i].a, vt[i].b, vt[i].c, vt[i].d);
      #1;
      chk("tbl_lat_early", bus.rsp_valid, 1'b0);
      @(negedge clk);
      #1;
      chk("tbl_rsp_valid", bus.rsp_valid, 1'b1);
      chk("tbl_rsp_s", bus.rsp_s, vt[i].s);
      chk("tbl_rsp_c", bus.rsp_c, vt[i].co);
      chk("tbl_rsp_id", bus.rsp_id, vt[i].id);
      @(negedge clk);
      #1;
      chk("tbl_ops_cnt", bus.ops_cnt, i + 1);
      chk("tbl_rsp_done", bus.rsp_valid, 1'b0);
      @(negedge clk);
    end

    // All requesters valid: rotating grants, back-to-back responses.
    set_ops(0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    set_ops(1, 8'h00, 8'h00, 8'h00, 8'h00);
    set_ops(2, 8'hF0, 8'h00, 8'h00, 8'h00);
    set_ops(3, 8'hFF, 8'hFF, 8'h00, 8'h00);
    bus.req_valid = 4'hF;
    for (int cy = 0; cy < 16; cy++) begin
      #1;
      g = bus.req_ready;
      chk("rr_grant", g, (cy < 12) ? (4'b0001 << (cy % 4)) : 4'b0000);
      chk("rr_rsp_valid", bus.rsp_valid, (cy >= 2 && cy <= 13));
      if (cy >= 2 && cy <= 13) begin
        chk("rr_rsp_id", bus.rsp_id, (cy - 2) % 4);
        chk("rr_rsp_s", bus.rsp_s, rr_s[(cy - 2) % 4]);
        chk("rr_rsp_c", bus.rsp_c, rr_c[(cy - 2) % 4]);
      end
      @(negedge clk);
      if (cy >= 8) bus.req_valid = bus.req_valid & ~g;
    end
    #1;
    chk("rr_ops_cnt", bus.ops_cnt, 16'd19);
    @(negedge clk);

    // Backpressure: two responses in flight, a third request waiting.
    bus.rsp_ready = 1'b0;
    do_xfer(1, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    do_xfer(1, 8'h0F, 8'h0F, 8'hF0, 8'h00);
    set_ops(3, 8'hFF, 8'h00, 8'hFF, 8'h00);
    bus.req_valid[3] = 1'b1;
    for (int cy = 0; cy < 5; cy++) begin
      #1;
      chk("bp_req_ready", bus.req_ready, 4'b0000);
      chk("bp_rsp_valid", bus.rsp_valid, 1'b1);
      chk("bp_rsp_s", bus.rsp_s, 8'h00);
      chk("bp_rsp_c", bus.rsp_c, 8'hFF);
      chk("bp_rsp_id", bus.rsp_id, 2'd1);
      chk("bp_ops_cnt", bus.ops_cnt, 16'd19);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_resume_ready", bus.req_ready, 4'b1000);
    @(negedge clk);
    bus.req_valid[3] = 1'b0;
    #1;
    chk("bp_rsp2_valid", bus.rsp_valid, 1'b1);
    chk("bp_rsp2_s", bus.rsp_s, 8'h0F);
    chk("bp_rsp2_c", bus.rsp_c, 8'h0F);
    chk("bp_rsp2_id", bus.rsp_id, 2'd1);
    @(negedge clk);
    #1;
    chk("bp_rsp3_valid", bus.rsp_valid, 1'b1);
    chk("bp_rsp3_s", bus.rsp_s, 8'hFF);
    chk("bp_rsp3_c", bus.rsp_c, 8'hFF);
    chk("bp_rsp3_id", bus.rsp_id, 2'd3);
    @(negedge clk);
    #1;
    chk("bp_drained", bus.rsp_valid, 1'b0);
    chk("bp_ops_cnt_end", bus.ops_cnt, 16'd22);
    @(negedge clk);

    // Reset while both stages hold data; rr_ptr is 3 just before reset.
    bus.rsp_ready = 1'b0;
    do_xfer(2, 8'h11, 8'h22, 8'h33, 8'h44);
    do_xfer(2, 8'h55, 8'h66, 8'h77, 8'h88);
    #1;
    chk("mid_full", bus.rsp_valid, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.rsp_valid, 1'b0);
    chk("mid_rst_ops", bus.ops_cnt, 16'd0);
    chk("mid_rst_s", bus.rsp_s, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int cy = 0; cy < 3; cy++) begin
      #1;
      chk("mid_no_stale", bus.rsp_valid, 1'b0);
      @(negedge clk);
    end
    set_ops(0, 8'h00, 8'h00, 8'h00, 8'h00);
    set_ops(3, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    bus.req_valid = 4'b1001;
    #1;
    chk("mid_first_grant", bus.req_ready, 4'b0001);
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    #1;
    chk("mid_second_grant", bus.req_ready, 4'b1000);
    @(negedge clk);
    bus.req_valid[3] = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("mid_ops_cnt", bus.ops_cnt, 16'd2);
    @(negedge clk);

    // Counter saturation: stream until 16'hFFFE, then three more completions.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_ops(0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0001;
    k = 0;
    while (bus.ops_cnt != 16'hFFFE && k < 70000) begin
      @(negedge clk);
      k++;
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    chk("sat_reach_fffe", (k < 70000), 1'b1);
    for (int cy = 0; cy < 3; cy++) begin
      #1;
      chk("sat_hold_fffe", bus.ops_cnt, 16'hFFFE);
      chk("sat_inflight", bus.rsp_valid, 1'b1);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    do_xfer(0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    #1;
    chk("sat_first", bus.ops_cnt, 16'hFFFF);
    repeat (4) @(negedge clk);
    #1;
    chk("sat_final", bus.ops_cnt, 16'hFFFF);
    chk("sat_drained", bus.rsp_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cmp42_bank_arbiter.md
# cmp42_bank_arbiter

Shares one bank of LANES approximate 4-2 compressor cells (pro_4) among NREQ requesters. A round-robin arbiter grants one valid/ready request per cycle. Granted operands pass through a two-stage pipeline (operand register, compressor, result register) to a single tagged response port with backpressure. The block sits between the partial-product generators of the approximate multipliers and the shared compression resource, and counts completed operations for characterisation runs.

## Interface
- NREQ, 4, number of requesters (2..4); ID width is 2 bits
- LANES, 8, number of compressor lanes, i.e. bit width of each operand vector
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  request valid, one bit per requester
- req_ready  out  NREQ  request accepted this cycle, one bit per requester
- req_a, req_b, req_c, req_d  in  NREQ*LANES each  operand vectors; requester i occupies bits [i*LANES +: LANES]
- rsp_valid  out  1  response valid
- rsp_ready  in  1  downstream accepts response
- rsp_s  out  LANES  per-lane sum outputs
- rsp_c  out  LANES  per-lane carry outputs
- rsp_id  out  2  index of the requester that issued the response
- ops_cnt  out  16  count of completed responses, saturating

## Operation
- Lane function, per bit j, with t1 = a^b and t2 = c^d:
  - S = t1 ? t2 : ~(c|d)
  - C = ~((~(a|b) & ~(c&d)) | (~(c|d) & ~(a&b)))
- The block instantiates LANES pro_4 cells; it does not model the function separately.
- Arbiter:
  - rr_ptr is 2 bits and resets to 0.
  - grant goes to the first i with req_valid[i]=1, scanning from rr_ptr upward modulo NREQ.
  - grant is combinational from req_valid and rr_ptr only.
- Handshake:
  - req_ready[i] = grant[i] & s1_load_ok.
  - At most one ready bit is high per cycle.
  - A request transfers when req_valid[i] & req_ready[i].
  - On a transfer, rr_ptr becomes (i+1) mod NREQ. With no transfer, rr_ptr holds.
- Requester rules: once req_valid is asserted, it and its operands stay stable until accepted. req_valid never depends on req_ready.
- Stage 1 holds s1_valid, the operands and the id.
  - s1_load_ok = ~s1_valid | s1_advance.
  - s1_advance = s1_valid & (~s2_valid | rsp_ready).
- Stage 2 holds the response registers.
  - On s1_advance it loads S/C from the pro_4 bank (stage-1 operands) and the id.
  - rsp_valid = s2_valid.
  - s2_valid clears when rsp_valid & rsp_ready and no s1_advance occurs in the same cycle.
- ops_cnt increments on every rsp_valid & rsp_ready and saturates at 16'hFFFF.
- The response port holds rsp_s, rsp_c and rsp_id stable while rsp_valid=1 and rsp_ready=0.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_s=0, rsp_c=0, rsp_id=0, ops_cnt=0. Internally rr_ptr=0, s1_valid=0, s2_valid=0.
- Reset asserted mid-operation discards in-flight data immediately. No response is emitted after release.
- Latency: a transfer in cycle n gives rsp_valid=1 in cycle n+2 if rsp_ready was not blocking.
- Throughput: with rsp_ready held at 1, the block sustains one transfer per cycle.
- Full pipe with rsp_ready=0: both stages stay valid and all req_ready=0. When rsp_ready returns to 1, transfers resume in that same cycle (s1_load_ok = 1 through the advance path).
- Response accepted in the same cycle stage 1 advances: s2 reloads and rsp_valid stays 1 with no bubble.
- Single requester continuously valid: it is granted every cycle.
- All requesters valid: grants rotate 0,1,2,3,0,... One grant per transfer.
- Requester deasserting without a transfer is illegal; the bench flags it.

## Test plan
- Reset, then requester 0 sends a=b=c=d=8'hFF -> 2 cycles later rsp_s=8'h00, rsp_c=8'hFF, rsp_id=0, ops_cnt=1 after the handshake.
- Requester 2 sends a=8'hF0, b=c=d=8'h00, then a=b=8'hFF, c=d=8'h00 -> responses in order: (S=8'h0F, C=8'h00, id=2), then (S=8'hFF, C=8'hFF, id=2).
- All four requesters valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1,2,3; one response per cycle after a 2-cycle fill.
- rsp_ready=0 for 5 cycles with two requests in flight -> rsp outputs stay frozen, req_ready=0 throughout; on release both responses emerge in order on consecutive cycles, and no data is lost or duplicated.
- rst_n pulsed low while both stages are valid -> rsp_valid=0 and ops_cnt=0 immediately; after release, no stale response appears and the next grant goes to requester 0.
- Force ops_cnt to 16'hFFFE, then complete 3 responses -> ops_cnt reads 16'hFFFF and holds.
